// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: ID/EX hazard sources, memory and interrupt
// status in; PC / IF/ID / ID/EX write and flush controls plus status out.
interface hazard_ctrl_if;
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;
  logic        IF_ID_UsesRt;
  logic        ID_EX_MemRd;
  logic [4:0]  ID_EX_Rt;
  logic        EX_BranchTaken;
  logic        ID_Jump;
  logic        Mem_Busy;
  logic        IRQ_Req;
  logic        IRQ_Mask;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Hold;
  logic        ID_EX_Flush;
  logic        IRQ_Take;
  logic        Bus_Error;
  logic [15:0] Stall_Count;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, ID_EX_MemRd, ID_EX_Rt,
           EX_BranchTaken, ID_Jump, Mem_Busy, IRQ_Req, IRQ_Mask,
    input  PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Hold, ID_EX_Flush,
           IRQ_Take, Bus_Error, Stall_Count
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, ID_EX_MemRd, ID_EX_Rt,
           EX_BranchTaken, ID_Jump, Mem_Busy, IRQ_Req, IRQ_Mask,
    output PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Hold, ID_EX_Flush,
           IRQ_Take, Bus_Error, Stall_Count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: Mealy decode of load-use, branch, jump,
// interrupt and memory-wait events into PC / IF/ID / ID/EX load/hold/flush.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT      = 64,
  parameter int IRQ_FLUSH_CYCLES = 2
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam int EW = $clog2(IRQ_FLUSH_CYCLES + 1);
  localparam logic [WW-1:0] WAIT_LIMIT  = WW'(MEM_TIMEOUT);
  localparam logic [EW-1:0] ENTRY_LIMIT = EW'(IRQ_FLUSH_CYCLES);

  typedef enum logic [1:0] {RUN, MEM_WAIT, IRQ_ENTRY} state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_hold;
    logic idex_flush;
    logic irq_take;
  } ctl_t;

  localparam ctl_t CTL_DEFAULT = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_HOLD    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctl_t CTL_FLUSH   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctl_t CTL_IRQ     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam ctl_t CTL_BUBBLE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctl_t CTL_JUMP    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_RESET   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_next;
  logic [EW-1:0] entry_cnt;
  logic          bus_error;
  logic [15:0]   stall_count;
  logic          load_use;
  logic          mem_hold;
  logic          irq_ok;
  ctl_t          run_ctl;
  ctl_t          ctl;

  assign load_use = hz.ID_EX_MemRd && (hz.ID_EX_Rt != 5'd0) &&
                    ((hz.ID_EX_Rt == hz.IF_ID_Rs) ||
                     (hz.IF_ID_UsesRt && (hz.ID_EX_Rt == hz.IF_ID_Rt)));
  // The cycle after a timeout releases the pipeline even if Mem_Busy is stuck.
  assign mem_hold  = hz.Mem_Busy && !bus_error;
  assign irq_ok    = hz.IRQ_Req && !hz.IRQ_Mask;
  assign wait_next = wait_cnt + WW'(1);

  always_comb begin
    if (mem_hold)               run_ctl = CTL_HOLD;
    else if (hz.EX_BranchTaken) run_ctl = CTL_FLUSH;
    else if (irq_ok)            run_ctl = CTL_IRQ;
    else if (load_use)          run_ctl = CTL_BUBBLE;
    else if (hz.ID_Jump)        run_ctl = CTL_JUMP;
    else                        run_ctl = CTL_DEFAULT;
  end

  always_comb begin
    ctl = run_ctl;
    if (reset) begin
      ctl = CTL_RESET;
    end else begin
      case (state)
        MEM_WAIT:  if (hz.Mem_Busy) ctl = CTL_HOLD;
        IRQ_ENTRY: ctl = hz.Mem_Busy ? CTL_HOLD : CTL_FLUSH;
        default:   ctl = run_ctl;
      endcase
    end
  end

  assign hz.PC_Write    = ctl.pc_write;
  assign hz.IF_ID_Write = ctl.ifid_write;
  assign hz.IF_ID_Flush = ctl.ifid_flush;
  assign hz.ID_EX_Hold  = ctl.idex_hold;
  assign hz.ID_EX_Flush = ctl.idex_flush;
  assign hz.IRQ_Take    = ctl.irq_take;
  assign hz.Bus_Error   = bus_error;
  assign hz.Stall_Count = stall_count;

  // MEM_WAIT without Mem_Busy falls through to the RUN rules in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      entry_cnt   <= '0;
      bus_error   <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      bus_error <= 1'b0;
      if (!ctl.pc_write && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
      case (state)
        IRQ_ENTRY: begin
          if (!hz.Mem_Busy) begin
            if ((entry_cnt + EW'(1)) >= ENTRY_LIMIT) begin
              state     <= RUN;
              entry_cnt <= '0;
            end else begin
              entry_cnt <= entry_cnt + EW'(1);
            end
          end
        end
        default: begin
          if (mem_hold) begin
            if (wait_next >= WAIT_LIMIT) begin
              bus_error <= 1'b1;
              state     <= RUN;
              wait_cnt  <= '0;
            end else begin
              state    <= MEM_WAIT;
              wait_cnt <= wait_next;
            end
          end else begin
            wait_cnt <= '0;
            if (!hz.EX_BranchTaken && irq_ok && (IRQ_FLUSH_CYCLES > 1)) begin
              state     <= IRQ_ENTRY;
              entry_cnt <= EW'(1);
            end else begin
              state <= RUN;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each cycle a reference model pushes the
// expected controls/status, which are popped and compared mid-cycle.
module tb_hazard_ctrl;
  localparam int TO    = 4;
  localparam int FLUSH = 2;

  localparam logic [5:0] DEF_C   = 6'b110000;
  localparam logic [5:0] HOLD_C  = 6'b000100;
  localparam logic [5:0] FLUSH_C = 6'b101010;
  localparam logic [5:0] IRQ_C   = 6'b101011;
  localparam logic [5:0] BUB_C   = 6'b000010;
  localparam logic [5:0] JMP_C   = 6'b101000;
  localparam logic [5:0] RST_C   = 6'b001010;

  localparam int ST_RUN = 0, ST_WAIT = 1, ST_ENTRY = 2;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic       memRd;
    logic [4:0] exRt;
    logic       br;
    logic       jmp;
    logic       busy;
    logic       irq;
    logic       mask;
  } stim_t;

  typedef struct packed {
    logic [5:0]  ctl;
    logic        be;
    logic [15:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  hazard_ctrl_if hzIf ();

  hazard_ctrl #(.MEM_TIMEOUT(TO), .IRQ_FLUSH_CYCLES(FLUSH)) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hzIf)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t expQ[$];

  int   mState = ST_RUN;
  int   mWait  = 0;
  int   mEntry = 0;
  bit   mBe    = 1'b0;
  int   mStall = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour: outputs from current model state, then advance it.
  task automatic modelCycle(input stim_t s, output exp_t e);
    logic [5:0] c;
    logic lu, hold, irqOk;
    lu    = s.memRd && (s.exRt != 0) &&
            ((s.exRt == s.rs) || (s.usesRt && (s.exRt == s.rt)));
    hold  = s.busy && !mBe;
    irqOk = s.irq && !s.mask;
    e.be    = mBe;
    e.stall = 16'(mStall);
    if (s.rst)                  c = RST_C;
    else if (mState == ST_ENTRY) c = s.busy ? HOLD_C : FLUSH_C;
    else if (hold)              c = HOLD_C;
    else if (s.br)              c = FLUSH_C;
    else if (irqOk)             c = IRQ_C;
    else if (lu)                c = BUB_C;
    else if (s.jmp)             c = JMP_C;
    else                        c = DEF_C;
    e.ctl = c;
    if (s.rst) begin
      mState = ST_RUN; mWait = 0; mEntry = 0; mBe = 1'b0; mStall = 0;
    end else begin
      if (!c[5] && mStall < 65535) mStall++;
      mBe = 1'b0;
      if (mState == ST_ENTRY) begin
        if (!s.busy) begin
          mEntry++;
          if (mEntry >= FLUSH) begin mState = ST_RUN; mEntry = 0; end
        end
      end else if (hold) begin
        mWait++;
        if (mWait >= TO) begin mBe = 1'b1; mState = ST_RUN; mWait = 0; end
        else mState = ST_WAIT;
      end else begin
        mWait = 0;
        if (!s.br && irqOk && FLUSH > 1) begin mState = ST_ENTRY; mEntry = 1; end
        else mState = ST_RUN;
      end
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Called #1 after a rising edge; compares mid-cycle, returns #1 after the next edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    exp_t got;
    reset                  = s.rst;
    hzIf.IF_ID_Rs          = s.rs;
    hzIf.IF_ID_Rt          = s.rt;
    hzIf.IF_ID_UsesRt      = s.usesRt;
    hzIf.ID_EX_MemRd       = s.memRd;
    hzIf.ID_EX_Rt          = s.exRt;
    hzIf.EX_BranchTaken    = s.br;
    hzIf.ID_Jump           = s.jmp;
    hzIf.Mem_Busy          = s.busy;
    hzIf.IRQ_Req           = s.irq;
    hzIf.IRQ_Mask          = s.mask;
    modelCycle(s, e);
    expQ.push_back(e);
    #3;
    if (expQ.size() == 0) begin
      checkOutput("sb_empty", 32'(0), 32'(1));
    end else begin
      got = expQ.pop_front();
      checkOutput("ctl", 32'({hzIf.PC_Write, hzIf.IF_ID_Write, hzIf.IF_ID_Flush,
                              hzIf.ID_EX_Hold, hzIf.ID_EX_Flush, hzIf.IRQ_Take}),
                  32'(got.ctl));
      checkOutput("bus_error", 32'(hzIf.Bus_Error), 32'(got.be));
      checkOutput("stall_count", 32'(hzIf.Stall_Count), 32'(got.stall));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    stim_t r;
    r = idle();
    r.rst = 1'b1;

    reset = 1'b1;
    hzIf.IF_ID_Rs = '0; hzIf.IF_ID_Rt = '0; hzIf.IF_ID_UsesRt = 1'b0;
    hzIf.ID_EX_MemRd = 1'b0; hzIf.ID_EX_Rt = '0; hzIf.EX_BranchTaken = 1'b0;
    hzIf.ID_Jump = 1'b0; hzIf.Mem_Busy = 1'b0; hzIf.IRQ_Req = 1'b0; hzIf.IRQ_Mask = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(r);
    applyStimulus(idle());

    // Load-use on Rs, then bubble cycle with no re-stall
    s = idle(); s.memRd = 1'b1; s.exRt = 5'd8; s.rs = 5'd8;
    applyStimulus(s);
    applyStimulus(idle());
    checkOutput("lu_stall_total", 32'(hzIf.Stall_Count), 32'(1));

    // No stall for $zero destination or unread Rt; stall for read Rt
    s = idle(); s.memRd = 1'b1; s.exRt = 5'd0; s.rs = 5'd0;
    applyStimulus(s);
    s = idle(); s.memRd = 1'b1; s.exRt = 5'd9; s.rt = 5'd9; s.rs = 5'd3;
    applyStimulus(s);
    s.usesRt = 1'b1;
    applyStimulus(s);

    // Branch wins over IRQ; IRQ taken next cycle, then one more flush cycle
    s = idle(); s.br = 1'b1; s.irq = 1'b1;
    applyStimulus(s);
    s = idle(); s.irq = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idle());

    // Masked interrupt, jump
    s = idle(); s.irq = 1'b1; s.mask = 1'b1;
    applyStimulus(s);
    s = idle(); s.jmp = 1'b1;
    applyStimulus(s);

    // Memory wait during a load-use, then the bubble
    applyStimulus(r);
    s = idle(); s.memRd = 1'b1; s.exRt = 5'd8; s.rs = 5'd8; s.busy = 1'b1;
    repeat (3) applyStimulus(s);
    s.busy = 1'b0;
    applyStimulus(s);
    applyStimulus(idle());
    checkOutput("busy_lu_stall_total", 32'(hzIf.Stall_Count), 32'(4));

    // Timeout: TO hold cycles then a single Bus_Error pulse
    applyStimulus(r);
    s = idle(); s.busy = 1'b1;
    repeat (TO) applyStimulus(s);
    checkOutput("timeout_pulse", 32'(hzIf.Bus_Error), 32'(1));
    applyStimulus(idle());
    checkOutput("timeout_pulse_end", 32'(hzIf.Bus_Error), 32'(0));
    checkOutput("timeout_stall_total", 32'(hzIf.Stall_Count), 32'(TO));
    applyStimulus(idle());

    // Reset in the middle of IRQ_ENTRY and in the middle of MEM_WAIT
    s = idle(); s.irq = 1'b1;
    applyStimulus(s);
    s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(idle());
    checkOutput("irq_reset_stall", 32'(hzIf.Stall_Count), 32'(0));
    s = idle(); s.busy = 1'b1;
    repeat (TO - 1) applyStimulus(s);
    applyStimulus(r);
    applyStimulus(idle());

    // Mem_Busy during IRQ_ENTRY freezes the entry counter
    s = idle(); s.irq = 1'b1;
    applyStimulus(s);
    s.busy = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    s.busy = 1'b0;
    applyStimulus(s);
    applyStimulus(idle());

    // Random traffic, small register numbers so hazards actually collide
    for (int i = 0; i < 400; i++) begin
      s        = idle();
      s.rst    = ($urandom_range(0, 49) == 0);
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.exRt   = 5'($urandom_range(0, 3));
      s.usesRt = 1'($urandom_range(0, 1));
      s.memRd  = 1'($urandom_range(0, 1));
      s.br     = ($urandom_range(0, 5) == 0);
      s.jmp    = ($urandom_range(0, 4) == 0);
      s.busy   = ($urandom_range(0, 3) == 0);
      s.irq    = ($urandom_range(0, 5) == 0);
      s.mask   = ($urandom_range(0, 2) == 0);
      applyStimulus(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
